// File: rtl/rs_pkg.sv
// Shared definitions for the reservation stations: tag constants and entry states.
package rs_pkg;

  // Tag 0 marks an operand whose value is already present.
  localparam int unsigned NOTAG = 0;

  // Tags owned by each functional-unit station.
  localparam int unsigned ADD_1 = 1;
  localparam int unsigned ADD_2 = 2;
  localparam int unsigned ADD_3 = 3;
  localparam int unsigned MUL_1 = 4;
  localparam int unsigned MUL_2 = 5;
  localparam int unsigned LD_1  = 6;
  localparam int unsigned LD_2  = 7;
  localparam int unsigned ST_1  = 8;
  localparam int unsigned ST_2  = 9;

  typedef enum logic [1:0] {
    FREE,
    WAIT,
    READY,
    ISSUED
  } entry_state_e;

endpackage

// File: rtl/rs_if.sv
// Dispatch, CDB and functional-unit handshake bundle of a reservation station.
interface rs_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned TAG_W  = 4,
  parameter int unsigned ROB_W  = 2
);
  logic              disp_valid;
  logic              disp_ready;
  logic [TAG_W-1:0]  disp_tag1;
  logic [TAG_W-1:0]  disp_tag2;
  logic [DATA_W-1:0] disp_op1;
  logic [DATA_W-1:0] disp_op2;
  logic [ROB_W-1:0]  disp_rob;
  logic [TAG_W-1:0]  alloc_tag;

  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;

  logic              fu_valid;
  logic              fu_ready;
  logic [DATA_W-1:0] fu_a;
  logic [DATA_W-1:0] fu_b;
  logic [TAG_W-1:0]  fu_tag;
  logic [ROB_W-1:0]  fu_rob;

  // Dispatcher / CDB / functional-unit side.
  modport master (
    output disp_valid, disp_tag1, disp_tag2, disp_op1, disp_op2, disp_rob,
    output cdb_valid, cdb_tag, cdb_data, fu_ready,
    input  disp_ready, alloc_tag, fu_valid, fu_a, fu_b, fu_tag, fu_rob
  );

  // Reservation-station side.
  modport slave (
    input  disp_valid, disp_tag1, disp_tag2, disp_op1, disp_op2, disp_rob,
    input  cdb_valid, cdb_tag, cdb_data, fu_ready,
    output disp_ready, alloc_tag, fu_valid, fu_a, fu_b, fu_tag, fu_rob
  );
endinterface

// File: rtl/rs_age_matrix.sv
// Allocation-order tracker: returns the oldest entry among those marked ready.
module rs_age_matrix #(
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DEPTH-1:0] alloc,
  input  logic [DEPTH-1:0] free,
  input  logic [DEPTH-1:0] ready,
  output logic [DEPTH-1:0] oldest
);

  // older[j][i] set means entry j was allocated before entry i.
  logic [DEPTH-1:0] older [DEPTH];
  logic [DEPTH-1:0] blocked;

  // New entry is younger than all others; freed entries drop out of every relation.
  // Stale bits in rows of free entries are cleared when that entry is next allocated.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned j = 0; j < DEPTH; j++) older[j] <= '0;
    end else begin
      for (int unsigned j = 0; j < DEPTH; j++) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (free[j] || free[i])       older[j][i] <= 1'b0;
          else if (alloc[i] && j != i)  older[j][i] <= 1'b1;
          else if (alloc[j])            older[j][i] <= 1'b0;
        end
      end
    end
  end

  // A ready entry wins unless some other ready entry is older.
  always_comb begin
    blocked = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      for (int unsigned j = 0; j < DEPTH; j++) begin
        if (j != i && ready[j] && older[j][i]) blocked[i] = 1'b1;
      end
    end
    oldest = ready & ~blocked;
  end

endmodule

// File: rtl/rs_unit.sv
// Parametrised Tomasulo reservation station for one functional-unit class.
module rs_unit
  import rs_pkg::*;
#(
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned TAG_W    = 4,
  parameter int unsigned ROB_W    = 2,
  parameter int unsigned BASE_TAG = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  rs_if.slave                          bus,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned CNT_W = $clog2(DEPTH+1);
  localparam logic [TAG_W-1:0] NT = TAG_W'(NOTAG);

  entry_state_e      st    [DEPTH];
  entry_state_e      st_n  [DEPTH];
  logic [TAG_W-1:0]  t1    [DEPTH];
  logic [TAG_W-1:0]  t1_n  [DEPTH];
  logic [TAG_W-1:0]  t2    [DEPTH];
  logic [TAG_W-1:0]  t2_n  [DEPTH];
  logic [DATA_W-1:0] o1    [DEPTH];
  logic [DATA_W-1:0] o1_n  [DEPTH];
  logic [DATA_W-1:0] o2    [DEPTH];
  logic [DATA_W-1:0] o2_n  [DEPTH];
  logic [ROB_W-1:0]  rob   [DEPTH];
  logic [ROB_W-1:0]  rob_n [DEPTH];

  logic [DEPTH-1:0] free_vec, ready_vec, alloc_oh, free_hit, sel;
  logic [DEPTH-1:0] age_alloc, age_free;
  logic             do_disp, do_issue;

  function automatic logic [TAG_W-1:0] own_tag(input int unsigned i);
    return TAG_W'(BASE_TAG + i);
  endfunction

  function automatic logic cdb_match(input logic v, input logic [TAG_W-1:0] ct,
                                     input logic [TAG_W-1:0] t);
    return v && (t != NT) && (ct == t);
  endfunction

  // Per-entry status masks and the lowest-index free slot for the next dispatch.
  always_comb begin
    free_vec  = '0;
    ready_vec = '0;
    free_hit  = '0;
    alloc_oh  = '0;
    bus.alloc_tag = NT;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      free_vec[i]  = (st[i] == FREE);
      ready_vec[i] = (st[i] == READY);
      free_hit[i]  = (st[i] == ISSUED) && bus.cdb_valid && (bus.cdb_tag == own_tag(i));
      if (free_vec[i] && alloc_oh == '0) begin
        alloc_oh[i]   = 1'b1;
        bus.alloc_tag = own_tag(i);
      end
    end
  end

  assign bus.disp_ready = |free_vec;
  assign busy           = ~|free_vec;
  assign do_disp        = bus.disp_valid && (|free_vec) && !flush;
  assign bus.fu_valid   = |ready_vec;
  assign do_issue       = bus.fu_valid && bus.fu_ready;

  // Flush reuses the free path to wipe every age relation at once.
  assign age_alloc = do_disp ? alloc_oh : '0;
  assign age_free  = flush ? '1 : free_hit;

  rs_age_matrix #(.DEPTH(DEPTH)) u_age (
    .clk    (clk),
    .rst    (rst),
    .alloc  (age_alloc),
    .free   (age_free),
    .ready  (ready_vec),
    .oldest (sel)
  );

  // Issue payload from the selected entry; all zero when nothing is ready.
  always_comb begin
    bus.fu_a   = '0;
    bus.fu_b   = '0;
    bus.fu_tag = NT;
    bus.fu_rob = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (sel[i]) begin
        bus.fu_a   = o1[i];
        bus.fu_b   = o2[i];
        bus.fu_tag = own_tag(i);
        bus.fu_rob = rob[i];
      end
    end
  end

  // Entry next state: dispatch capture with CDB bypass, wakeup, issue and free.
  always_comb begin
    st_n  = st;
    t1_n  = t1;
    t2_n  = t2;
    o1_n  = o1;
    o2_n  = o2;
    rob_n = rob;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      case (st[i])
        FREE: begin
          if (do_disp && alloc_oh[i]) begin
            if (cdb_match(bus.cdb_valid, bus.cdb_tag, bus.disp_tag1)) begin
              t1_n[i] = NT;
              o1_n[i] = bus.cdb_data;
            end else begin
              t1_n[i] = bus.disp_tag1;
              o1_n[i] = bus.disp_op1;
            end
            if (cdb_match(bus.cdb_valid, bus.cdb_tag, bus.disp_tag2)) begin
              t2_n[i] = NT;
              o2_n[i] = bus.cdb_data;
            end else begin
              t2_n[i] = bus.disp_tag2;
              o2_n[i] = bus.disp_op2;
            end
            rob_n[i] = bus.disp_rob;
            st_n[i]  = (t1_n[i] == NT && t2_n[i] == NT) ? READY : WAIT;
          end
        end
        WAIT: begin
          if (cdb_match(bus.cdb_valid, bus.cdb_tag, t1[i])) begin
            t1_n[i] = NT;
            o1_n[i] = bus.cdb_data;
          end
          if (cdb_match(bus.cdb_valid, bus.cdb_tag, t2[i])) begin
            t2_n[i] = NT;
            o2_n[i] = bus.cdb_data;
          end
          st_n[i] = (t1_n[i] == NT && t2_n[i] == NT) ? READY : WAIT;
        end
        READY: begin
          if (do_issue && sel[i]) st_n[i] = ISSUED;
        end
        ISSUED: begin
          if (free_hit[i]) st_n[i] = FREE;
        end
      endcase
    end
  end

  // Entry states and occupancy count; rst and flush both empty the station.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) st[i] <= FREE;
      count <= '0;
    end else begin
      st    <= st_n;
      count <= count + CNT_W'(do_disp) - CNT_W'(|free_hit);
    end
  end

  // Entry payload; only meaningful while the entry is not FREE.
  always_ff @(posedge clk) begin
    t1  <= t1_n;
    t2  <= t2_n;
    o1  <= o1_n;
    o2  <= o2_n;
    rob <= rob_n;
  end

endmodule
